// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback path: data/address widths, load
// funct3 encodings and the writeback source selector.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Which stream owns the regfile write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head read, so the consumer can
// write the head out in the same cycle it dequeues it.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the buffered ALU stream and the priority load
// stream into one registered regfile write port, with load data extraction.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN           = cpu_pkg::XLEN,
  parameter int AW             = cpu_pkg::AW,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [AW-1:0]                     alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              lsu_valid,
  input  logic [AW-1:0]                     lsu_rd,
  input  logic [XLEN-1:0]                   lsu_rdata,
  input  logic [2:0]                        lsu_funct3,
  input  logic [1:0]                        lsu_addr_lo,
  output logic                              rf_we,
  output logic [AW-1:0]                     rf_waddr,
  output logic [XLEN-1:0]                   rf_wdata,
  output logic                              load_err,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   alu_fifo_cnt
);

  // Returns {err, data}; err covers both misalignment and illegal funct3.
  function automatic logic [XLEN:0] load_extract(
    input logic [XLEN-1:0] rdata,
    input logic [2:0]      f3,
    input logic [1:0]      lo
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic            err;
    logic [XLEN-1:0] d;
    b   = rdata[8*lo +: 8];
    h   = rdata[16*lo[1] +: 16];
    err = 1'b0;
    d   = '0;
    case (f3)
      F3_LB:  d = {{(XLEN-8){b[7]}}, b};
      F3_LBU: d = {{(XLEN-8){1'b0}}, b};
      F3_LH: begin
        err = lo[0];
        d   = {{(XLEN-16){h[15]}}, h};
      end
      F3_LHU: begin
        err = lo[0];
        d   = {{(XLEN-16){1'b0}}, h};
      end
      F3_LW: begin
        err = (lo != 2'b00);
        d   = rdata;
      end
      default: err = 1'b1;
    endcase
    return {err, d};
  endfunction

  logic             alu_fire;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+XLEN-1:0] fifo_dout;
  logic [AW-1:0]    head_rd;
  logic [XLEN-1:0]  head_data;
  logic [XLEN:0]    ld_res;
  logic             ld_err;
  logic [XLEN-1:0]  ld_data;
  wb_src_e          src;

  logic             rf_we_reg,    rf_we_next;
  logic [AW-1:0]    rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0]  rf_wdata_reg, rf_wdata_next;
  logic             load_err_reg, load_err_next;

  // Ready depends on the registered count only, never on this cycle's pop.
  assign alu_ready = !rst && !fifo_full;
  assign alu_fire  = alu_valid && alu_ready;

  assign ld_res  = load_extract(lsu_rdata, lsu_funct3, lsu_addr_lo);
  assign ld_err  = ld_res[XLEN];
  assign ld_data = ld_res[XLEN-1:0];

  assign head_rd   = fifo_dout[AW+XLEN-1:XLEN];
  assign head_data = fifo_dout[XLEN-1:0];

  sync_fifo #(
    .WIDTH (AW + XLEN),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({alu_rd, alu_data}),
    .dout  (fifo_dout),
    .count (alu_fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    src = SRC_NONE;
    if (lsu_valid) begin
      src = SRC_LOAD;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end else if (alu_fire) begin
      src = SRC_ALU;
    end
  end

  // A bypassed ALU result goes straight out; every other accepted one queues.
  assign fifo_push = alu_fire && (src != SRC_ALU);
  assign fifo_pop  = (src == SRC_FIFO);

  always_comb begin
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    load_err_next = 1'b0;
    case (src)
      SRC_LOAD: begin
        if (ld_err) begin
          load_err_next = 1'b1;
        end else begin
          rf_we_next    = |lsu_rd;
          rf_waddr_next = lsu_rd;
          rf_wdata_next = ld_data;
        end
      end
      SRC_FIFO: begin
        rf_we_next    = |head_rd;
        rf_waddr_next = head_rd;
        rf_wdata_next = head_data;
      end
      SRC_ALU: begin
        rf_we_next    = |alu_rd;
        rf_waddr_next = alu_rd;
        rf_wdata_next = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      load_err_reg <= 1'b0;
    end else begin
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      load_err_reg <= load_err_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1 time unit after each rising
// edge, registered outputs are checked 1 time unit after the following edge.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic [1:0]  alu_fifo_cnt;

  int total;
  int bad;

  wb_arbiter #(.XLEN(32), .AW(5), .ALU_FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_rdata    (lsu_rdata),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr_lo  (lsu_addr_lo),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .load_err     (load_err),
    .alu_fifo_cnt (alu_fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Checks the full write-port state after one output cycle.
  task automatic check_wr(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [1:0] cnt);
    check({tag, ".we"},   {31'd0, rf_we}, {31'd0, we});
    check({tag, ".wa"},   {27'd0, rf_waddr}, {27'd0, wa});
    check({tag, ".wd"},   rf_wdata, wd);
    check({tag, ".cnt"},  {30'd0, alu_fifo_cnt}, {30'd0, cnt});
    $display("txn %s: we=%0d waddr=%0d wdata=0x%08h cnt=%0d err=%0d",
             tag, rf_we, rf_waddr, rf_wdata, alu_fifo_cnt, load_err);
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic [2:0] f3, input logic [1:0] lo);
    lsu_valid   = v;
    lsu_rd      = rd;
    lsu_rdata   = d;
    lsu_funct3  = f3;
    lsu_addr_lo = lo;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    step();
    step();

    // Reset state
    check("rst.ready", {31'd0, alu_ready}, 32'd0);
    check("rst.err",   {31'd0, load_err}, 32'd0);
    check_wr("rst", 1'b0, 5'd0, 32'd0, 2'd0);
    rst = 1'b0;
    #1;
    check("post_rst.ready", {31'd0, alu_ready}, 32'd1);

    // Lone ALU op: bypass with latency 1
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    check_wr("alu_bypass", 1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
    step();
    check_wr("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF, 2'd0);

    // Load contention: loads win, ALU results queue in order
    set_lsu(1'b1, 5'd7, 32'h11223344, 3'b010, 2'd0);
    set_alu(1'b1, 5'd1, 32'h00000101);
    step();
    check_wr("cont.ld1", 1'b1, 5'd7, 32'h11223344, 2'd1);
    set_alu(1'b1, 5'd2, 32'h00000202);
    step();
    check_wr("cont.ld2", 1'b1, 5'd7, 32'h11223344, 2'd2);
    check("cont.ready_full", {31'd0, alu_ready}, 32'd0);
    set_alu(1'b1, 5'd3, 32'h00000303);
    step();
    check_wr("cont.ld3", 1'b1, 5'd7, 32'h11223344, 2'd2);
    set_lsu(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    step();
    check_wr("cont.x1", 1'b1, 5'd1, 32'h00000101, 2'd1);
    check("cont.ready_again", {31'd0, alu_ready}, 32'd1);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    check_wr("cont.x2", 1'b1, 5'd2, 32'h00000202, 2'd1);
    step();
    check_wr("cont.x3", 1'b1, 5'd3, 32'h00000303, 2'd0);

    // Load extension on 0x80FF7F01
    set_lsu(1'b1, 5'd9, 32'h80FF7F01, 3'b000, 2'd1);
    step();
    check_wr("ext.lb1", 1'b1, 5'd9, 32'h0000007F, 2'd0);
    set_lsu(1'b1, 5'd9, 32'h80FF7F01, 3'b000, 2'd3);
    step();
    check_wr("ext.lb3", 1'b1, 5'd9, 32'hFFFFFF80, 2'd0);
    set_lsu(1'b1, 5'd9, 32'h80FF7F01, 3'b100, 2'd2);
    step();
    check_wr("ext.lbu2", 1'b1, 5'd9, 32'h000000FF, 2'd0);
    set_lsu(1'b1, 5'd9, 32'h80FF7F01, 3'b001, 2'd2);
    step();
    check_wr("ext.lh2", 1'b1, 5'd9, 32'hFFFF80FF, 2'd0);
    set_lsu(1'b1, 5'd9, 32'h80FF7F01, 3'b101, 2'd0);
    step();
    check_wr("ext.lhu0", 1'b1, 5'd9, 32'h00007F01, 2'd0);
    check("ext.no_err", {31'd0, load_err}, 32'd0);

    // Load errors; an ALU op offered alongside must queue, not dequeue
    set_lsu(1'b1, 5'd10, 32'h12345678, 3'b010, 2'd2);
    set_alu(1'b1, 5'd4, 32'h00000404);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    check("err.lw2.err", {31'd0, load_err}, 32'd1);
    check("err.lw2.we",  {31'd0, rf_we}, 32'd0);
    check("err.lw2.cnt", {30'd0, alu_fifo_cnt}, 32'd1);
    set_lsu(1'b1, 5'd10, 32'h12345678, 3'b001, 2'd1);
    step();
    check("err.lh1.err", {31'd0, load_err}, 32'd1);
    check("err.lh1.we",  {31'd0, rf_we}, 32'd0);
    check("err.lh1.cnt", {30'd0, alu_fifo_cnt}, 32'd1);
    set_lsu(1'b1, 5'd10, 32'h12345678, 3'b011, 2'd0);
    step();
    check("err.f3_011.err", {31'd0, load_err}, 32'd1);
    check("err.f3_011.we",  {31'd0, rf_we}, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    step();
    check("err.pulse_end", {31'd0, load_err}, 32'd0);
    check_wr("err.drain_x4", 1'b1, 5'd4, 32'h00000404, 2'd0);

    // Writes to x0: bypass, load, and a queued entry all consumed silently
    set_alu(1'b1, 5'd0, 32'h00000055);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    check_wr("x0.alu", 1'b0, 5'd0, 32'h00000055, 2'd0);
    set_lsu(1'b1, 5'd0, 32'h0000AAAA, 3'b010, 2'd0);
    set_alu(1'b1, 5'd0, 32'h00000077);
    step();
    set_lsu(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    check_wr("x0.load", 1'b0, 5'd0, 32'h0000AAAA, 2'd1);
    step();
    check_wr("x0.drain", 1'b0, 5'd0, 32'h00000077, 2'd0);

    // Reset mid-operation with two buffered entries
    set_lsu(1'b1, 5'd8, 32'hCAFEF00D, 3'b010, 2'd0);
    set_alu(1'b1, 5'd11, 32'h00000B0B);
    step();
    set_alu(1'b1, 5'd12, 32'h00000C0C);
    step();
    check_wr("mid.fill", 1'b1, 5'd8, 32'hCAFEF00D, 2'd2);
    set_lsu(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("mid.ready_in_rst", {31'd0, alu_ready}, 32'd0);
    step();
    rst = 1'b0;
    check_wr("mid.rst", 1'b0, 5'd0, 32'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wr("mid.no_stale", 1'b0, 5'd0, 32'd0, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
